// File: rtl/cond_flag_unit.sv
// +--------------------------------------------------------------------------+
// | cond_flag_unit                                                           |
// | Jump-condition select, control flags/irq mask and interrupt service FSM. |
// | Option macro: COND_FLAG_UNIT_IRQ_EDGE_EN (edge-capture irq when defined).|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module cond_flag_unit #(
  parameter int DATA_W   = 32,
  parameter int NFLAGS   = 4,
  parameter int FLAG_LSB = 26,
  parameter int NIRQ     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     state_fetch,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        ob,
  input  logic [DATA_W-1:0]        r,
  input  logic [DATA_W:0]          alu,
  input  logic                     aeqm,
  input  logic                     vmaok,
  input  logic [3:0]               cond_sel,
  input  logic                     cond_inv,
  input  logic [NIRQ-1:0]          irq,
  input  logic                     int_ack,
  output logic                     jcond,
  output logic [NFLAGS-1:0]        flags,
  output logic [NIRQ-1:0]          irq_mask,
  output logic                     int_pending,
  output logic [$clog2(NIRQ)-1:0]  int_vec
);

  localparam int c_VEC_W = $clog2(NIRQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OFFER = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NFLAGS-1:0]   r_flags;
  logic [NIRQ-1:0]     r_irq_mask;
  logic [NIRQ-1:0]     r_pend;
  logic [c_VEC_W-1:0]  r_int_vec;
  logic [c_VEC_W-1:0]  w_vec_nxt;
  logic [c_VEC_W-1:0]  w_low_vec;
  logic [NIRQ-1:0]     w_req;
  logic [NIRQ-1:0]     w_irq_set;
  logic [NIRQ-1:0]     w_ack_clr;
  logic [NIRQ-1:0]     w_pend_nxt;
  logic                w_wr;
  logic                w_ack;
  logic                w_aluneg;
  logic                w_pgf_int;
  logic                w_pgf_int_sb;
  logic                w_sel;
  logic                w_unused_bits;

  assign w_wr  = state_fetch & wr_en;
  assign w_req = r_pend & r_irq_mask;
  assign w_ack = (r_state == S_OFFER) && int_ack;

`ifdef COND_FLAG_UNIT_IRQ_EDGE_EN
  logic [NIRQ-1:0] r_irq_prev;

  always_ff @(posedge clk) begin
    if (reset) r_irq_prev <= '0;
    else       r_irq_prev <= irq;
  end

  assign w_irq_set = irq & ~r_irq_prev;
`else
  assign w_irq_set = irq;
`endif

  // Scan downward so the lowest requesting index is the one left standing.
  always_comb begin
    w_low_vec = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (w_req[i]) w_low_vec = c_VEC_W'(i);
    end
  end

  always_comb begin
    w_ack_clr = '0;
    for (int i = 0; i < NIRQ; i++) begin
      w_ack_clr[i] = w_ack && (r_int_vec == c_VEC_W'(i));
    end
  end

  // A new request on the bit being acknowledged beats the clear.
  assign w_pend_nxt = (r_pend & ~w_ack_clr) | w_irq_set;

  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_int_vec;
    case (r_state)
      S_IDLE: begin
        if (r_flags[1] && (|w_req)) begin
          w_state_nxt = S_OFFER;
          w_vec_nxt   = w_low_vec;
        end
      end
      S_OFFER: begin
        if (int_ack)                                   w_state_nxt = S_HOLD;
        else if (!r_flags[1] || !r_irq_mask[r_int_vec]) w_state_nxt = S_IDLE;
      end
      S_HOLD:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_flags    <= '0;
      r_irq_mask <= '0;
      r_pend     <= '0;
      r_int_vec  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_int_vec <= w_vec_nxt;
      r_pend    <= w_pend_nxt;
      if (w_wr) begin
        r_flags    <= ob[FLAG_LSB +: NFLAGS];
        r_irq_mask <= ob[NIRQ-1:0];
      end
    end
  end

  assign w_aluneg     = ~aeqm & alu[DATA_W];
  assign w_pgf_int    = ~vmaok | int_pending;
  assign w_pgf_int_sb = w_pgf_int | r_flags[0];

  always_comb begin
    w_sel = 1'b0;
    case (cond_sel)
      4'd0: w_sel = r[0];
      4'd1: w_sel = w_aluneg;
      4'd2: w_sel = alu[DATA_W];
      4'd3: w_sel = aeqm;
      4'd4: w_sel = ~vmaok;
      4'd5: w_sel = w_pgf_int;
      4'd6: w_sel = w_pgf_int_sb;
      4'd7: w_sel = 1'b1;
      4'd8: w_sel = |w_req;
      default: begin
        // Selects 9..15 map to flags[2..8]; absent flags read as 0.
        for (int i = 2; i < NFLAGS; i++) begin
          if (cond_sel == 4'(i + 7)) w_sel = r_flags[i];
        end
      end
    endcase
  end

  assign jcond       = w_sel ^ cond_inv;
  assign flags       = r_flags;
  assign irq_mask    = r_irq_mask;
  assign int_pending = (r_state == S_OFFER);
  assign int_vec     = r_int_vec;

  assign w_unused_bits = &{1'b0, ob, r[DATA_W-1:1], alu[DATA_W-1:0]};

endmodule

`default_nettype wire

// File: tb/tb_cond_flag_unit.sv
// +--------------------------------------------------------------------------+
// | tb_cond_flag_unit                                                        |
// | Directed scoreboard bench for cond_flag_unit (default parameters).       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_cond_flag_unit;

`ifdef COND_FLAG_UNIT_IRQ_EDGE_EN
  localparam bit c_LEVEL = 1'b0;
`else
  localparam bit c_LEVEL = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        state_fetch;
  logic        wr_en;
  logic [31:0] ob;
  logic [31:0] r;
  logic [32:0] alu;
  logic        aeqm;
  logic        vmaok;
  logic [3:0]  cond_sel;
  logic        cond_inv;
  logic [3:0]  irq;
  logic        int_ack;
  logic        jcond;
  logic [3:0]  flags;
  logic [3:0]  irq_mask;
  logic        int_pending;
  logic [1:0]  int_vec;

  typedef struct {
    string       tag;
    logic [11:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  cond_flag_unit dut (
    .clk         (clk),
    .reset       (reset),
    .state_fetch (state_fetch),
    .wr_en       (wr_en),
    .ob          (ob),
    .r           (r),
    .alu         (alu),
    .aeqm        (aeqm),
    .vmaok       (vmaok),
    .cond_sel    (cond_sel),
    .cond_inv    (cond_inv),
    .irq         (irq),
    .int_ack     (int_ack),
    .jcond       (jcond),
    .flags       (flags),
    .irq_mask    (irq_mask),
    .int_pending (int_pending),
    .int_vec     (int_vec)
  );

  always #5 clk = ~clk;

  task automatic expect_out(input string tag, input logic j, input logic [3:0] f,
                            input logic [3:0] m, input logic p, input logic [1:0] v);
    exp_t e;
    e.tag = tag;
    e.val = {j, f, m, p, v};
    sb.push_back(e);
  endtask

  // Advance one edge, then compare DUT outputs with the oldest expectation.
  task automatic tick_check();
    exp_t        e;
    logic [11:0] obs;
    @(posedge clk);
    #1;
    obs = {jcond, flags, irq_mask, int_pending, int_vec};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed={j,f,m,p,v}=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic write_fm(input logic [31:0] data);
    state_fetch = 1'b1;
    wr_en       = 1'b1;
    ob          = data;
  endtask

  task automatic write_off();
    state_fetch = 1'b0;
    wr_en       = 1'b0;
    ob          = '0;
  endtask

  logic [15:0] sel_tab;

  initial begin
    reset = 1'b1; state_fetch = 1'b0; wr_en = 1'b0; ob = '0; r = '0; alu = '0;
    aeqm = 1'b0; vmaok = 1'b1; cond_sel = 4'd7; cond_inv = 1'b0; irq = '0; int_ack = 1'b0;
    sel_tab = 16'h04C6;

    @(posedge clk); #1;
    expect_out("reset", 1, 4'h0, 4'h0, 0, 2'd0); tick_check();
    reset = 1'b0;

    // Flag/mask write and hold
    write_fm(32'h0C00_0005);
    expect_out("wr_load", 1, 4'h3, 4'h5, 0, 2'd0); tick_check();
    wr_en = 1'b0; ob = '1;
    expect_out("fetch_no_wr", 1, 4'h3, 4'h5, 0, 2'd0); tick_check();
    state_fetch = 1'b0; wr_en = 1'b1;
    expect_out("wr_no_fetch", 1, 4'h3, 4'h5, 0, 2'd0); tick_check();

    // Priority offer and acknowledge
    write_fm(32'h0800_000F);
    expect_out("wr_enable", 1, 4'h2, 4'hF, 0, 2'd0); tick_check();
    write_off(); irq = 4'b1010;
    expect_out("irq_pend", 1, 4'h2, 4'hF, 0, 2'd0); tick_check();
    irq = 4'b0000; cond_sel = 4'd8;
    expect_out("offer_v1", 1, 4'h2, 4'hF, 1, 2'd1); tick_check();
    int_ack = 1'b1; cond_sel = 4'd7;
    expect_out("ack_hold", 1, 4'h2, 4'hF, 0, 2'd1); tick_check();
    int_ack = 1'b0;
    expect_out("hold_idle", 1, 4'h2, 4'hF, 0, 2'd1); tick_check();
    expect_out("offer_v3", 1, 4'h2, 4'hF, 1, 2'd3); tick_check();
    int_ack = 1'b1;
    expect_out("ack_v3", 1, 4'h2, 4'hF, 0, 2'd3); tick_check();
    cond_sel = 4'd8;
    expect_out("ack_in_hold", 0, 4'h2, 4'hF, 0, 2'd3); tick_check();
    expect_out("ack_in_idle", 0, 4'h2, 4'hF, 0, 2'd3); tick_check();
    int_ack = 1'b0; cond_sel = 4'd7;

    // Withdraw on int_enable drop, then re-offer
    irq = 4'b0100;
    expect_out("irq2", 1, 4'h2, 4'hF, 0, 2'd3); tick_check();
    irq = 4'b0000;
    expect_out("offer_v2", 1, 4'h2, 4'hF, 1, 2'd2); tick_check();
    write_fm(32'h0000_000F);
    expect_out("disable_in_offer", 1, 4'h0, 4'hF, 1, 2'd2); tick_check();
    write_off(); cond_sel = 4'd8;
    expect_out("withdraw_pend_kept", 1, 4'h0, 4'hF, 0, 2'd2); tick_check();
    write_fm(32'h0800_000F);
    expect_out("reenable", 1, 4'h2, 4'hF, 0, 2'd2); tick_check();
    write_off(); cond_sel = 4'd7;
    expect_out("reoffer_v2", 1, 4'h2, 4'hF, 1, 2'd2); tick_check();
    int_ack = 1'b1;
    expect_out("ack_v2", 1, 4'h2, 4'hF, 0, 2'd2); tick_check();
    int_ack = 1'b0;
    expect_out("hold_v2", 1, 4'h2, 4'hF, 0, 2'd2); tick_check();

    // Condition select sweep
    write_fm(32'h2400_0000);
    expect_out("wr_1001", 1, 4'h9, 4'h0, 0, 2'd2); tick_check();
    write_off(); alu = 33'h1_0000_0000; aeqm = 1'b0; vmaok = 1'b1; r = '0;
    for (int inv = 0; inv < 2; inv++) begin
      for (int s = 0; s < 16; s++) begin
        cond_sel = 4'(s);
        cond_inv = 1'(inv);
        expect_out($sformatf("sel%0d_inv%0d", s, inv), sel_tab[s] ^ 1'(inv),
                   4'h9, 4'h0, 0, 2'd2);
        tick_check();
      end
    end
    alu = '0; cond_sel = 4'd7; cond_inv = 1'b0;

    // irq held high across an acknowledge
    write_fm(32'h0800_0001);
    expect_out("wr_m1", 1, 4'h2, 4'h1, 0, 2'd2); tick_check();
    write_off(); irq = 4'b0001;
    expect_out("irq0_set", 1, 4'h2, 4'h1, 0, 2'd2); tick_check();
    expect_out("offer_v0", 1, 4'h2, 4'h1, 1, 2'd0); tick_check();
    int_ack = 1'b1; cond_sel = 4'd8;
    expect_out("ack_held_irq", c_LEVEL, 4'h2, 4'h1, 0, 2'd0); tick_check();
    int_ack = 1'b0; cond_sel = 4'd7;
    expect_out("hold_v0", 1, 4'h2, 4'h1, 0, 2'd0); tick_check();
    expect_out("reoffer_v0", 1, 4'h2, 4'h1, c_LEVEL, 2'd0); tick_check();
    irq = 4'b0000; reset = 1'b1;
    expect_out("reset_mid", 1, 4'h0, 4'h0, 0, 2'd0); tick_check();
    reset = 1'b0;

    // Reset during an offer with simultaneous ack/irq/write
    write_fm(32'h0800_000F);
    expect_out("wr_final", 1, 4'h2, 4'hF, 0, 2'd0); tick_check();
    write_off(); irq = 4'b1000;
    expect_out("irq3", 1, 4'h2, 4'hF, 0, 2'd0); tick_check();
    irq = 4'b0000; cond_sel = 4'd5;
    expect_out("offer_pgf", 1, 4'h2, 4'hF, 1, 2'd3); tick_check();
    reset = 1'b1; int_ack = 1'b1; irq = 4'b0001; write_fm(32'hFFFF_FFFF);
    expect_out("reset_in_offer", 0, 4'h0, 4'h0, 0, 2'd0); tick_check();
    reset = 1'b0; int_ack = 1'b0; irq = 4'b0000; write_fm(32'h0000_000F); cond_sel = 4'd8;
    expect_out("pend_cleared", 0, 4'h0, 4'hF, 0, 2'd0); tick_check();
    write_off();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cond_flag_unit.md
COND_FLAG_UNIT -- requirements
Module: cond_flag_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width of ob/r; alu is DATA_W+1 bits.
REQ-002 SHALL have parameter NFLAGS, default 4, range 2..8, number of control flag bits.
REQ-003 SHALL have parameter FLAG_LSB, default 26, ob bit position of flags[0]; FLAG_LSB+NFLAGS <= DATA_W.
REQ-004 SHALL have parameter NIRQ, default 4, range 2..16, number of interrupt request lines; NIRQ <= FLAG_LSB.
REQ-005 SHALL have the port clk  in  1  clock; all state changes on the rising edge.
REQ-006 SHALL have the port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have the port state_fetch  in  1  fetch-state strobe.
REQ-008 SHALL have the port wr_en  in  1  flag/mask write destination select.
REQ-009 SHALL have the ports ob  in  DATA_W  write data, and r  in  DATA_W  test operand.
REQ-010 SHALL have the ports alu  in  DATA_W+1  ALU result with carry, aeqm  in  1  A equals M, and vmaok  in  1  VMA access ok.
REQ-011 SHALL have the ports cond_sel  in  4  condition select, and cond_inv  in  1  invert selected condition.
REQ-012 SHALL have the ports irq  in  NIRQ  interrupt requests, and int_ack  in  1  service acknowledge.
REQ-013 SHALL have the ports jcond  out  1  jump condition, flags  out  NFLAGS  control flags, irq_mask  out  NIRQ  enable mask, int_pending  out  1  interrupt offered, and int_vec  out  clog2(NIRQ)  offered line index.

Function
REQ-014 flags[0] SHALL be sequence_break and flags[1] SHALL be int_enable; flags[NFLAGS-1:2] are general-purpose.
REQ-015 When state_fetch & wr_en is high, on that edge flags SHALL load ob[FLAG_LSB+NFLAGS-1:FLAG_LSB] and irq_mask SHALL load ob[NIRQ-1:0]; otherwise both SHALL hold.
REQ-016 pend[NIRQ-1:0] SHALL be an internal register; each bit is set per REQ-030/031 and cleared only by an acknowledge (REQ-020) or by reset.
REQ-017 The service FSM SHALL have states IDLE, OFFER and HOLD.
REQ-018 In IDLE, when (pend & irq_mask) is nonzero and flags[1]=1, the FSM SHALL capture the lowest-index such bit into int_vec and enter OFFER on the next edge.
REQ-019 In OFFER, int_pending SHALL be 1 and int_vec SHALL be stable; int_pending SHALL be 0 in IDLE and HOLD.
REQ-020 In OFFER with int_ack=1, the FSM SHALL clear pend[int_vec] and enter HOLD; a set request on that same bit in that same edge SHALL win.
REQ-021 In OFFER, if flags[1] or irq_mask[int_vec] drops to 0 without int_ack, the FSM SHALL withdraw to IDLE and leave pend unchanged.
REQ-022 HOLD SHALL last exactly one cycle and then return to IDLE; int_ack outside OFFER SHALL be ignored.
REQ-023 Derived terms: aluneg = ~aeqm & alu[DATA_W]; sint = int_pending; pgf_int = ~vmaok | sint; pgf_int_sb = pgf_int | flags[0].
REQ-024 cond_sel SHALL select as follows: 0 r[0]; 1 aluneg; 2 alu[DATA_W]; 3 aeqm; 4 ~vmaok; 5 pgf_int; 6 pgf_int_sb; 7 constant 1; 8 |(pend & irq_mask).
REQ-025 cond_sel values 9..15 SHALL select flags[cond_sel-7] when cond_sel-7 < NFLAGS, and 0 otherwise.
REQ-026 jcond SHALL equal the selected term XOR cond_inv; it is combinational with zero latency.

Reset
REQ-027 On reset, flags, irq_mask and pend SHALL clear to 0, the FSM SHALL go to IDLE, int_pending SHALL be 0 and int_vec SHALL be 0.
REQ-028 Reset SHALL override a simultaneous write, irq or int_ack; reset during OFFER SHALL drop the offer with no acknowledge effect.

Configuration
REQ-029 Macro COND_FLAG_UNIT_IRQ_EDGE_EN SHALL select edge versus level capture of irq.
REQ-030 With COND_FLAG_UNIT_IRQ_EDGE_EN defined, the block SHALL register irq, and pend[i] SHALL set on a 0->1 transition of irq[i]; the first edge after reset sees a previous value of 0.
REQ-031 Without COND_FLAG_UNIT_IRQ_EDGE_EN, pend[i] SHALL set on every edge while irq[i]=1; there SHALL be no irq history register.

Verification
REQ-032 Scenario: write with ob=32'h0C00_0005 (FLAG_LSB=26) -> flags=4'b0011, irq_mask=4'b0101 the next cycle; with wr_en=0, flags and irq_mask are unchanged.
REQ-033 Scenario: flags[1]=1, mask=4'hF, irq=4'b1010 -> int_pending=1 with int_vec=1; ack -> HOLD; next offer is int_vec=3.
REQ-034 Scenario: OFFER on vec 2, then write flags[1]=0 -> withdraw to IDLE, pend[2] still 1; re-enable -> vec 2 offered again.
REQ-035 Scenario: cond_sel sweep 0..15 with alu[32]=1, aeqm=0, vmaok=1, flags=4'b1001, cond_inv both values -> jcond matches REQ-024/025 (sel 6=1, sel 10=1, sel 11=0).
REQ-036 Scenario: edge build, irq[0] held high across an ack -> no second pend set; level build, same stimulus -> pend[0] re-set and vec 0 offered again.
REQ-037 Scenario: reset asserted during OFFER together with int_ack -> all outputs 0 next cycle and pend=0.
